// File: rtl/eth_rx_frame_ctrl.sv
// Frame sequencer between the RX 8->32 buffer and uDMA: one-entry output register (1-cycle accept-to-valid),
// tready only while armed and the output slot is free or draining; drops tuser/oversize frames and counts them.
module eth_rx_frame_ctrl #(
   parameter int LEN_WIDTH      = 16,
   parameter int DROP_CNT_WIDTH = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cfg_en_i,
   input  logic                      cfg_continuous_i,
   input  logic                      cfg_clr_i,
   input  logic [LEN_WIDTH-1:0]      cfg_max_len_i,
   input  logic [31:0]               s_axis_tdata,
   input  logic [1:0]                s_axis_byte_count,
   input  logic                      s_axis_tvalid,
   input  logic                      s_axis_tuser,
   input  logic                      s_axis_tlast,
   output logic                      s_axis_tready,
   output logic [31:0]               data_rx_o,
   output logic [1:0]                data_rx_bytes_o,
   output logic                      data_rx_valid_o,
   input  logic                      data_rx_ready_i,
   output logic                      busy_o,
   output logic                      frame_done_o,
   output logic [LEN_WIDTH-1:0]      frame_len_o,
   output logic                      err_user_o,
   output logic                      err_ovf_o,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DROP, ST_DONE} state_e;

   state_e                    state_q, state_d;
   logic                      out_vld_q, out_vld_d;
   logic [31:0]               out_dat_q, out_dat_d;
   logic [1:0]                out_bytes_q, out_bytes_d;
   logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0]      frame_len_q, frame_len_d;
   logic                      frame_done_q, frame_done_d;
   logic                      err_user_q, err_user_d;
   logic                      err_ovf_q, err_ovf_d;
   logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

   logic                      accept;
   logic                      drop_evt;
   logic                      ovf;
   logic [LEN_WIDTH:0]        sum_ext;

   always_comb begin
      s_axis_tready = 1'b0;
      case (state_q)
         ST_RECV: s_axis_tready = ~out_vld_q | data_rx_ready_i;
         ST_DROP: s_axis_tready = 1'b1;
         default: s_axis_tready = 1'b0;
      endcase
   end

   assign accept  = s_axis_tvalid & s_axis_tready;
   // One extra bit so a sum past the limit is never hidden by wrap-around.
   assign sum_ext = {1'b0, cnt_q} + (LEN_WIDTH+1)'(s_axis_byte_count) + (LEN_WIDTH+1)'(1);
   assign ovf     = (cfg_max_len_i != '0) && (sum_ext > {1'b0, cfg_max_len_i});

   always_comb begin
      state_d      = state_q;
      out_vld_d    = out_vld_q & ~data_rx_ready_i;
      out_dat_d    = out_dat_q;
      out_bytes_d  = out_bytes_q;
      cnt_d        = cnt_q;
      frame_len_d  = frame_len_q;
      frame_done_d = 1'b0;
      err_user_d   = err_user_q;
      err_ovf_d    = err_ovf_q;
      drop_cnt_d   = drop_cnt_q;
      drop_evt     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_en_i) begin
               state_d    = ST_RECV;
               err_user_d = 1'b0;
               err_ovf_d  = 1'b0;
            end
         end
         ST_RECV: begin
            if (accept) begin
               if (s_axis_tuser) begin
                  err_user_d = 1'b1;
                  drop_evt   = 1'b1;
                  state_d    = s_axis_tlast ? ST_DONE : ST_DROP;
               end else if (ovf) begin
                  err_ovf_d = 1'b1;
                  drop_evt  = 1'b1;
                  state_d   = s_axis_tlast ? ST_DONE : ST_DROP;
               end else begin
                  out_vld_d   = 1'b1;
                  out_dat_d   = s_axis_tdata;
                  out_bytes_d = s_axis_byte_count;
                  cnt_d       = sum_ext[LEN_WIDTH] ? '1 : sum_ext[LEN_WIDTH-1:0];
                  if (s_axis_tlast) state_d = ST_DONE;
               end
            end
         end
         ST_DROP: begin
            if (accept && s_axis_tlast) state_d = ST_DONE;
         end
         ST_DONE: begin
            cnt_d   = '0;
            state_d = cfg_continuous_i ? ST_RECV : ST_IDLE;
         end
      endcase

      if (drop_evt && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);

      // Done pulse and length are registered on entry so both are visible during the DONE cycle.
      if (state_d == ST_DONE) begin
         frame_done_d = 1'b1;
         frame_len_d  = cnt_d;
      end

      if (cfg_clr_i) begin
         state_d      = ST_IDLE;
         out_vld_d    = 1'b0;
         cnt_d        = '0;
         err_user_d   = 1'b0;
         err_ovf_d    = 1'b0;
         drop_cnt_d   = '0;
         frame_done_d = 1'b0;
         frame_len_d  = frame_len_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         out_vld_q    <= 1'b0;
         out_dat_q    <= '0;
         out_bytes_q  <= '0;
         cnt_q        <= '0;
         frame_len_q  <= '0;
         frame_done_q <= 1'b0;
         err_user_q   <= 1'b0;
         err_ovf_q    <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         out_vld_q    <= out_vld_d;
         out_dat_q    <= out_dat_d;
         out_bytes_q  <= out_bytes_d;
         cnt_q        <= cnt_d;
         frame_len_q  <= frame_len_d;
         frame_done_q <= frame_done_d;
         err_user_q   <= err_user_d;
         err_ovf_q    <= err_ovf_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign data_rx_o       = out_dat_q;
   assign data_rx_bytes_o = out_bytes_q;
   assign data_rx_valid_o = out_vld_q;
   assign busy_o          = (state_q != ST_IDLE);
   assign frame_done_o    = frame_done_q;
   assign frame_len_o     = frame_len_q;
   assign err_user_o      = err_user_q;
   assign err_ovf_o       = err_ovf_q;
   assign drop_cnt_o      = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed bench for eth_rx_frame_ctrl: stimulus pushes expected beats and frame lengths into queues,
// an independent monitor pops and compares whenever the DUT presents a beat or a done pulse.
module tb_eth_rx_frame_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cfg_en_i, cfg_continuous_i, cfg_clr_i;
   logic [15:0] cfg_max_len_i;
   logic [31:0] s_axis_tdata;
   logic [1:0]  s_axis_byte_count;
   logic        s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_tready;
   logic [31:0] data_rx_o;
   logic [1:0]  data_rx_bytes_o;
   logic        data_rx_valid_o, data_rx_ready_i;
   logic        busy_o, frame_done_o, err_user_o, err_ovf_o;
   logic [15:0] frame_len_o;
   logic [7:0]  drop_cnt_o;

   eth_rx_frame_ctrl #(.LEN_WIDTH(16), .DROP_CNT_WIDTH(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cfg_en_i(cfg_en_i), .cfg_continuous_i(cfg_continuous_i), .cfg_clr_i(cfg_clr_i),
      .cfg_max_len_i(cfg_max_len_i),
      .s_axis_tdata(s_axis_tdata), .s_axis_byte_count(s_axis_byte_count),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .data_rx_o(data_rx_o), .data_rx_bytes_o(data_rx_bytes_o),
      .data_rx_valid_o(data_rx_valid_o), .data_rx_ready_i(data_rx_ready_i),
      .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_len_o(frame_len_o),
      .err_user_o(err_user_o), .err_ovf_o(err_ovf_o), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] dat;
      logic [1:0]  bc;
   } beat_t;

   beat_t exp_q[$];
   int    len_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    done_cnt = 0;
   int    rdy_mode = 1;      // 0: hold low, 1: hold high, 2: toggle every cycle
   bit    chk_stall = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // uDMA ready generator
   initial begin
      data_rx_ready_i = 1'b1;
      forever begin
         @(posedge clk_i); #1;
         case (rdy_mode)
            0: data_rx_ready_i = 1'b0;
            2: data_rx_ready_i = ~data_rx_ready_i;
            default: data_rx_ready_i = 1'b1;
         endcase
      end
   end

   // Monitor / scoreboard
   initial begin
      beat_t       e;
      int          l;
      bit          stall_prev = 0;
      logic [31:0] prev_dat = '0;
      logic [1:0]  prev_bc = '0;
      forever begin
         @(negedge clk_i);
         if (stall_prev) begin
            check("stall_valid_held", 32'(data_rx_valid_o), 32'd1);
            check("stall_data_held", data_rx_o, prev_dat);
            check("stall_bytes_held", 32'(data_rx_bytes_o), 32'(prev_bc));
         end
         if (chk_stall && data_rx_valid_o && !data_rx_ready_i)
            check("stall_tready_low", 32'(s_axis_tready), 32'd0);
         if (data_rx_valid_o === 1'b1 && data_rx_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL beat_unexpected: got data 0x%0h, no beat expected", data_rx_o);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", data_rx_o, e.dat);
               check("beat_bytes", 32'(data_rx_bytes_o), 32'(e.bc));
            end
         end
         if (frame_done_o === 1'b1) begin
            done_cnt++;
            if (len_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL done_unexpected: got frame_len %0d, no frame end expected", frame_len_o);
            end else begin
               l = len_q.pop_front();
               check("frame_len", 32'(frame_len_o), 32'(l));
            end
         end
         stall_prev = chk_stall && (data_rx_valid_o === 1'b1) && (data_rx_ready_i === 1'b0);
         prev_dat   = data_rx_o;
         prev_bc    = data_rx_bytes_o;
      end
   end

   task automatic send(input logic [31:0] d, input logic [1:0] bc, input logic u,
                       input logic l, input bit fwd);
      bit acc = 0;
      int guard = 0;
      s_axis_tdata      = d;
      s_axis_byte_count = bc;
      s_axis_tuser      = u;
      s_axis_tlast      = l;
      s_axis_tvalid     = 1'b1;
      if (fwd) exp_q.push_back('{dat: d, bc: bc});
      while (!acc && guard < 100) begin
         @(negedge clk_i);
         acc = s_axis_tready;
         @(posedge clk_i); #1;
         guard++;
      end
      if (!acc) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: word 0x%0h not accepted, required acceptance", d);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic arm();
      cfg_en_i = 1'b1;
      @(posedge clk_i); #1;
      cfg_en_i = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int guard = 0;
      while (done_cnt < target && guard < 100) begin
         @(negedge clk_i);
         guard++;
      end
      check("done_reached", 32'(done_cnt), 32'(target));
   endtask

   task automatic wait_drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(negedge clk_i);
         guard++;
      end
      check("beats_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1;
      cfg_en_i = 0; cfg_continuous_i = 0; cfg_clr_i = 0; cfg_max_len_i = '0;
      s_axis_tdata = '0; s_axis_byte_count = '0;
      s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_tready", 32'(s_axis_tready), 32'd0);
      check("rst_valid", 32'(data_rx_valid_o), 32'd0);
      check("rst_data", data_rx_o, 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(frame_done_o), 32'd0);
      check("rst_len", 32'(frame_len_o), 32'd0);
      check("rst_errs", 32'({err_user_o, err_ovf_o}), 32'd0);
      check("rst_drop", 32'(drop_cnt_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // 1: basic frame, ready high, 4+4+2 bytes
      arm();
      check("t1_busy_armed", 32'(busy_o), 32'd1);
      send(32'h11223344, 2'd3, 1'b0, 1'b0, 1'b1);
      check("t1_latency_valid", 32'(data_rx_valid_o), 32'd1);
      send(32'h55667788, 2'd3, 1'b0, 1'b0, 1'b1);
      len_q.push_back(10);
      send(32'h0000AABB, 2'd1, 1'b0, 1'b1, 1'b1);
      wait_done(1);
      repeat (3) @(negedge clk_i);
      check("t1_single_done", 32'(done_cnt), 32'd1);
      check("t1_idle", 32'(busy_o), 32'd0);
      check("t1_tready_idle", 32'(s_axis_tready), 32'd0);
      wait_drain();

      // 2: same frame with uDMA ready toggling
      rdy_mode  = 2;
      chk_stall = 1;
      arm();
      send(32'h11223344, 2'd3, 1'b0, 1'b0, 1'b1);
      send(32'h55667788, 2'd3, 1'b0, 1'b0, 1'b1);
      len_q.push_back(10);
      send(32'h0000AABB, 2'd1, 1'b0, 1'b1, 1'b1);
      wait_done(2);
      wait_drain();
      chk_stall = 0;
      rdy_mode  = 1;
      repeat (2) @(negedge clk_i);

      // 3: max length 6, three full words -> first forwarded, rest dropped
      cfg_max_len_i = 16'd6;
      arm();
      send(32'hA1A2A3A4, 2'd3, 1'b0, 1'b0, 1'b1);
      send(32'hB1B2B3B4, 2'd3, 1'b0, 1'b0, 1'b0);
      len_q.push_back(4);
      send(32'hC1C2C3C4, 2'd3, 1'b0, 1'b1, 1'b0);
      wait_done(3);
      @(negedge clk_i);
      check("t3_err_ovf", 32'(err_ovf_o), 32'd1);
      check("t3_err_user", 32'(err_user_o), 32'd0);
      check("t3_drop_cnt", 32'(drop_cnt_o), 32'd1);
      wait_drain();

      // 4: tuser on word 2 of 4
      cfg_max_len_i = '0;
      arm();
      check("t4_arm_clears_ovf", 32'(err_ovf_o), 32'd0);
      send(32'h00D1D1D1, 2'd2, 1'b0, 1'b0, 1'b1);
      send(32'hD2D2D2D2, 2'd3, 1'b1, 1'b0, 1'b0);
      send(32'hD3D3D3D3, 2'd3, 1'b0, 1'b0, 1'b0);
      len_q.push_back(3);
      send(32'h000000D4, 2'd0, 1'b0, 1'b1, 1'b0);
      wait_done(4);
      @(negedge clk_i);
      check("t4_err_user", 32'(err_user_o), 32'd1);
      check("t4_err_ovf", 32'(err_ovf_o), 32'd0);
      check("t4_drop_cnt", 32'(drop_cnt_o), 32'd2);
      wait_drain();

      // 5: continuous mode, two back-to-back frames with a single arm
      cfg_continuous_i = 1'b1;
      arm();
      len_q.push_back(4);
      send(32'hE1E2E3E4, 2'd3, 1'b0, 1'b1, 1'b1);
      len_q.push_back(1);
      send(32'h000000EE, 2'd0, 1'b0, 1'b1, 1'b1);
      wait_done(6);
      wait_drain();
      @(negedge clk_i);
      check("t5_still_armed", 32'(busy_o), 32'd1);

      // 6: clr together with en while a word is pending in the output register
      rdy_mode = 0;
      @(posedge clk_i); #1;
      send(32'h12345678, 2'd3, 1'b0, 1'b0, 1'b0);
      check("t6_pending_valid", 32'(data_rx_valid_o), 32'd1);
      check("t6_drop_before_clr", 32'(drop_cnt_o), 32'd2);
      cfg_clr_i = 1'b1;
      cfg_en_i  = 1'b1;
      cfg_continuous_i = 1'b0;
      @(posedge clk_i); #1;
      cfg_clr_i = 1'b0;
      cfg_en_i  = 1'b0;
      @(negedge clk_i);
      check("t6_idle", 32'(busy_o), 32'd0);
      check("t6_valid_cleared", 32'(data_rx_valid_o), 32'd0);
      check("t6_drop_cleared", 32'(drop_cnt_o), 32'd0);
      check("t6_tready", 32'(s_axis_tready), 32'd0);
      check("t6_errs_cleared", 32'({err_user_o, err_ovf_o}), 32'd0);
      repeat (3) @(negedge clk_i);
      check("t6_stays_idle", 32'(busy_o), 32'd0);
      rdy_mode = 1;
      repeat (2) @(negedge clk_i);

      check("end_beats_left", 32'(exp_q.size()), 32'd0);
      check("end_lens_left", 32'(len_q.size()), 32'd0);
      check("end_done_total", 32'(done_cnt), 32'd6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_rx_frame_ctrl.md
Name: eth_rx_frame_ctrl

Overview:
- Frame-level sequencer on the read side of the Ethernet RX 8→32 buffer. It sits between the buffer's 32-bit AXIS master port and the uDMA RX channel.
- It accepts frames only while armed by software, forwards words through a one-entry output register, and counts frame bytes.
- It enforces a maximum frame length and discards errored (tuser) or oversized frames. Status, a completion pulse and a saturating drop counter are reported back to the register file.

Parameters:
- LEN_WIDTH, 16: width of length configuration, byte counter and frame_len_o.
- DROP_CNT_WIDTH, 8: width of the saturating dropped-frame counter.

Ports:
- clk_i  in  1  single clock (the buffer's m_clk_i domain).
- rst_i  in  1  synchronous, active-high reset.
- cfg_en_i  in  1  one-cycle pulse; arms the controller for the next frame.
- cfg_continuous_i  in  1  1 = re-arm automatically after each frame.
- cfg_clr_i  in  1  one-cycle pulse; synchronous abort and clear.
- cfg_max_len_i  in  LEN_WIDTH  maximum accepted frame length in bytes; 0 = no limit.
- s_axis_tdata  in  32  word from the RX buffer, valid bytes in the low lanes.
- s_axis_byte_count  in  2  number of valid bytes minus 1.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tuser  in  1  frame error flag.
- s_axis_tlast  in  1  last word of the frame.
- s_axis_tready  out  1  stream ready.
- data_rx_o  out  32  word to uDMA.
- data_rx_bytes_o  out  2  valid bytes minus 1 for data_rx_o.
- data_rx_valid_o  out  1  uDMA valid.
- data_rx_ready_i  in  1  uDMA ready.
- busy_o  out  1  1 in any state other than IDLE.
- frame_done_o  out  1  one-cycle pulse at frame end.
- frame_len_o  out  LEN_WIDTH  byte length of the last completed frame.
- err_user_o  out  1  sticky; set by tuser, cleared on arm or clr.
- err_ovf_o  out  1  sticky; set by length overflow, cleared on arm or clr.
- drop_cnt_o  out  DROP_CNT_WIDTH  saturating count of dropped frames.

Behaviour:
- Reset values (rst_i high at a clock edge): state=IDLE, s_axis_tready=0, data_rx_valid_o=0, data_rx_o=0, data_rx_bytes_o=0, busy_o=0, frame_done_o=0, frame_len_o=0, err_*=0, drop_cnt_o=0, byte counter=0.
- Handshake: a word transfers when tvalid & tready are both high. Likewise a uDMA beat transfers when valid & ready are both high.
  - The output register loads when empty or drained in the same cycle. This gives 1-cycle latency from accept to data_rx_valid_o.
  - data_rx_* is held stable while data_rx_valid_o=1 and data_rx_ready_i=0.
- States:
  - IDLE: tready=0 (the buffer FIFO absorbs traffic). cfg_en_i → RECV and clears err_*.
  - RECV: tready = ~out_valid | data_rx_ready_i. For each accepted word, n = byte_count+1.
    - tuser=1: word not forwarded; err_user_o=1; drop_cnt increments (saturates). If tlast=1 → DONE, otherwise → DROP.
    - cfg_max_len_i≠0 and counter+n > cfg_max_len_i: word not forwarded; err_ovf_o=1; drop_cnt increments. If tlast=1 → DONE, otherwise → DROP. Words already forwarded are not recalled.
    - Otherwise: word forwarded, counter += n (saturates at all-ones). If tlast=1 → DONE.
  - DROP: tready=1; all words discarded. An accepted tlast → DONE.
  - DONE: lasts one cycle. frame_done_o=1 and frame_len_o = counter. counter=0. Next state is RECV if cfg_continuous_i=1, otherwise IDLE.
- Counter width and saturation: the counter is LEN_WIDTH bits wide. Sums are computed at LEN_WIDTH+1 bits for the overflow compare.
- Pending output: DONE does not wait for the output register to drain. A pending word stays valid until the uDMA takes it.
- cfg_clr_i (any state): → IDLE, output register invalidated, counter=0, err_*=0, drop_cnt=0. cfg_clr_i has priority over cfg_en_i in the same cycle.
- cfg_en_i outside IDLE: ignored.
- Reset or clr mid-frame: the remaining words of that frame are consumed as a new frame after re-arm. Software is responsible for resynchronising, e.g. by arming in DROP mode via a max_len of 1.

Test Plan:
1. Arm; 3 words, byte_count=3,3,1, tlast on the 3rd, ready=1 → 3 uDMA beats with 1-cycle latency; frame_done_o pulses once; frame_len_o=10; IDLE.
2. Same frame with data_rx_ready_i toggling 0/1 every cycle → data held stable while stalled, no beats lost or duplicated, s_axis_tready=0 during stalls; frame_len_o=10.
3. cfg_max_len_i=6; frame of 3 full words → 1 beat forwarded; err_ovf_o=1; drop_cnt_o=1; remainder drained in DROP; frame_done_o pulses with frame_len_o=4.
4. tuser=1 on word 2 of 4 → word 1 forwarded only; DROP consumes words 3–4; err_user_o=1; drop_cnt_o increments.
5. cfg_continuous_i=1; two back-to-back frames (4 and 1 bytes) → two frame_done_o pulses; frame_len_o=4 then 1; no re-arm needed.
6. cfg_clr_i together with cfg_en_i mid-frame, output word pending → next cycle: IDLE, data_rx_valid_o=0, drop_cnt_o=0, tready=0.
